// File: rtl/addmul_pipe_hs.sv
// Three-stage elastic add / half-word-multiply pipeline with valid/ready handshake.
// Optional build macro ADDMUL_SAT_EN makes the stage-1 sum saturate instead of wrap.
module addmul_pipe_hs #(
   parameter int W     = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_c,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       occ
);

   localparam int H = W / 2;

   logic             r_v1, r_v2, r_v3;
   logic [W-1:0]     r_d1, r_d2, r_d3;
   logic [TAG_W-1:0] r_t1, r_t2, r_t3;

   logic             w_ld1, w_ld2, w_ld3;
   logic [W:0]       w_sum_full;
   logic [W-1:0]     w_sum;
   logic [W-1:0]     w_prod2;
   logic [W-1:0]     w_prod3;

   // A stage may load when it is empty or when its own content moves on this cycle.
   assign w_ld3 = !r_v3 | out_ready;
   assign w_ld2 = !r_v2 | w_ld3;
   assign w_ld1 = !r_v1 | w_ld2;

   assign w_sum_full = {1'b0, in_a} + {1'b0, in_b};
`ifdef ADDMUL_SAT_EN
   assign w_sum = w_sum_full[W] ? {W{1'b1}} : w_sum_full[W-1:0];
`else
   assign w_sum = w_sum_full[W-1:0];
`endif

   assign w_prod2 = {{H{1'b0}}, r_d1[H-1:0]} * {{H{1'b0}}, r_d1[W-1:H]};
   assign w_prod3 = {{H{1'b0}}, r_d2[H-1:0]} * {{H{1'b0}}, r_d2[W-1:H]};

   // NOTE: non-blocking assignments keep every stage sampling the pre-edge value of its upstream neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_d1 <= '0;
         r_t1 <= '0;
      end else if (w_ld1) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_d1 <= w_sum;
            r_t1 <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2 <= 1'b0;
         r_d2 <= '0;
         r_t2 <= '0;
      end else if (w_ld2) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_d2 <= w_prod2;
            r_t2 <= r_t1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v3 <= 1'b0;
         r_d3 <= '0;
         r_t3 <= '0;
      end else if (w_ld3) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_d3 <= w_prod3;
            r_t3 <= r_t2;
         end
      end
   end

   assign in_ready  = w_ld1;
   assign out_valid = r_v3;
   assign out_c     = r_d3;
   assign out_tag   = r_t3;
   assign occ       = {1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_v3};

endmodule
